// File: rtl/housekeeping_spi_sync.sv
// housekeeping_spi_sync: SPI housekeeping slave oversampled on wb_clk_i.
// Optional management/user pass-through states are enabled by defining HKSPI_SYNC_PASSTHRU_EN.
module housekeeping_spi_sync #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rstn_i,
  input  logic              sck,
  input  logic              csb,
  input  logic              sdi,
  output logic              sdo,
  output logic              sdoenb,
  input  logic [1:0]        spi_mode,
  output logic              busy,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic              wrstb,
  output logic              rdstb,
  output logic              pass_thru_mgmt,
  output logic              pass_thru_user
);
  typedef enum logic [2:0] {S_CMD, S_ADDR, S_DATA, S_MGMT, S_USER} state_t;
  localparam logic [5:0] ALAST = 6'(ADDR_W - 1);
  localparam logic [5:0] DLAST = 6'(DATA_W - 1);
  state_t r_state;
  logic [SYNC_STAGES-1:0] r_sck_s, r_csb_s, r_sdi_s, r_fill;
  logic r_sck_d, r_armed, r_busy, r_write, r_read, r_first, r_more;
  logic r_s1, r_s2, r_c1, r_wrstb, r_rdstb;
  logic [5:0] r_cnt;
  logic [6:0] r_cmd;
  logic [2:0] r_n, r_wcnt;
  logic [DATA_W-2:0] r_wsh;
  logic [DATA_W-1:0] r_rsh, r_rdbuf;
  logic w_sck, w_csb, w_sdi, w_rise, w_fall, w_lead, w_trail;
  logic w_go, w_smp, w_shf, w_done, w_last, w_mgmt, w_user;
  logic [DATA_W-1:0] w_rd;
  assign w_sck   = r_sck_s[SYNC_STAGES-1];
  assign w_csb   = r_csb_s[SYNC_STAGES-1];
  assign w_sdi   = r_sdi_s[SYNC_STAGES-1];
  assign w_rise  = w_sck & ~r_sck_d;
  assign w_fall  = ~w_sck & r_sck_d;
  assign w_lead  = spi_mode[1] ? w_fall : w_rise;
  assign w_trail = spi_mode[1] ? w_rise : w_fall;
  assign w_go    = r_armed & ~w_csb;
  assign w_smp   = w_go & (spi_mode[0] ? w_trail : w_lead);
  assign w_shf   = w_go & (spi_mode[0] ? w_lead : w_trail);
  assign w_done  = w_smp & (r_state == S_DATA) & (r_cnt == DLAST);
  assign w_last  = (r_n != 3'd0) & (r_wcnt + 3'd1 == r_n);
  // a capture landing in the same cycle as the word's first shift edge is forwarded
  assign w_rd    = r_c1 ? rdata : r_rdbuf;
`ifdef HKSPI_SYNC_PASSTHRU_EN
  assign w_mgmt         = r_cmd[1];
  assign w_user         = r_cmd[0];
  assign pass_thru_mgmt = r_state == S_MGMT;
  assign pass_thru_user = r_state == S_USER;
`else
  assign w_mgmt         = 1'b0;
  assign w_user         = 1'b0;
  assign pass_thru_mgmt = 1'b0;
  assign pass_thru_user = 1'b0;
`endif
  assign sdo    = r_rsh[DATA_W-1];
  assign sdoenb = ~((r_state == S_DATA && r_read) || r_state == S_MGMT || r_state == S_USER);
  assign busy   = r_busy;
  assign wrstb  = r_wrstb;
  assign rdstb  = r_rdstb;

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      r_sck_s <= '0;
      r_csb_s <= '1;
      r_sdi_s <= '0;
      r_fill  <= '0;
      r_sck_d <= 1'b0;
    end else begin
      r_sck_s <= {r_sck_s[SYNC_STAGES-2:0], sck};
      r_csb_s <= {r_csb_s[SYNC_STAGES-2:0], csb};
      r_sdi_s <= {r_sdi_s[SYNC_STAGES-2:0], sdi};
      r_fill  <= {r_fill[SYNC_STAGES-2:0], 1'b1};
      r_sck_d <= w_sck;
    end
  end

  // word pipeline: wdata -> wrstb -> addr++ -> rdstb -> rdata capture
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      r_state <= S_CMD;
      r_armed <= 1'b0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_wcnt  <= '0;
      r_cmd   <= '0;
      r_write <= 1'b0;
      r_read  <= 1'b0;
      r_n     <= '0;
      r_first <= 1'b0;
      r_more  <= 1'b0;
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_c1    <= 1'b0;
      r_wrstb <= 1'b0;
      r_rdstb <= 1'b0;
      r_wsh   <= '0;
      r_rsh   <= '0;
      r_rdbuf <= '0;
      addr    <= '0;
      wdata   <= '0;
    end else begin
      r_wrstb <= w_done & r_write;
      r_s1    <= w_done;
      r_s2    <= r_s1;
      r_rdstb <= (r_s2 & r_read & r_more & ~w_csb) |
                 (w_smp & (r_state == S_ADDR) & (r_cnt == ALAST) & r_read);
      r_c1    <= r_rdstb;
      if (r_c1) r_rdbuf <= rdata;
      if (r_s1) addr <= addr + ADDR_W'(1);
      if (w_csb && r_fill[SYNC_STAGES-1]) r_armed <= 1'b1;
      if (w_csb) r_busy <= 1'b0;
      else if (w_smp) r_busy <= 1'b1;
      if (w_csb) begin
        r_state <= S_CMD;
        r_cnt   <= '0;
        r_wcnt  <= '0;
      end else begin
        if (w_shf && r_state == S_DATA) begin
          r_rsh   <= r_first ? w_rd : r_rsh << 1;
          r_first <= 1'b0;
        end
        if (w_smp) begin
          r_cnt <= r_cnt + 6'd1;
          case (r_state)
            S_CMD: begin
              r_cmd <= {r_cmd[5:0], w_sdi};
              if (r_cnt == 6'd7) begin
                r_cnt   <= '0;
                r_wcnt  <= '0;
                r_write <= r_cmd[6];
                r_read  <= r_cmd[5];
                r_n     <= r_cmd[4:2];
                r_state <= w_mgmt ? S_MGMT : (w_user ? S_USER : S_ADDR);
              end
            end
            S_ADDR: begin
              addr <= {addr[ADDR_W-2:0], w_sdi};
              if (r_cnt == ALAST) begin
                r_cnt   <= '0;
                r_first <= 1'b1;
                r_state <= S_DATA;
              end
            end
            S_DATA: begin
              r_wsh <= {r_wsh[DATA_W-3:0], w_sdi};
              if (r_cnt == DLAST) begin
                r_cnt   <= '0;
                wdata   <= {r_wsh, w_sdi};
                r_wcnt  <= r_wcnt + 3'd1;
                r_first <= 1'b1;
                r_more  <= ~w_last;
                if (w_last) r_state <= S_CMD;
              end
            end
            default: r_cnt <= '0;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_housekeeping_spi_sync.sv
// tb_housekeeping_spi_sync: randomized SPI master with queue scoreboard for housekeeping_spi_sync
module tb_housekeeping_spi_sync;
  localparam int S = 2;
  logic clk = 1'b0, rstn, sck, csb, sdi, sdo, sdoenb, busy, wrstb, rdstb, pm, pu;
  logic [1:0] mode;
  logic [7:0] addr, wdata, rdata;
  int n_cmp = 0, n_bad = 0;
  logic [15:0] exp_wr[$];
  logic [7:0] exp_rs[$], exp_rd[$], got_rd[$], fixd[$];
  bit txq[$];

  always #5 clk = ~clk;
  assign rdata = addr + 8'd1;

  housekeeping_spi_sync dut (
    .wb_clk_i(clk), .wb_rstn_i(rstn), .sck(sck), .csb(csb), .sdi(sdi),
    .sdo(sdo), .sdoenb(sdoenb), .spi_mode(mode), .busy(busy),
    .addr(addr), .wdata(wdata), .rdata(rdata), .wrstb(wrstb), .rdstb(rdstb),
    .pass_thru_mgmt(pm), .pass_thru_user(pu)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wrstb) begin
      if (exp_wr.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL wr_unexpected: got addr=%0h wdata=%0h required no write", addr, wdata);
      end else chk("wr_addr_data", {addr, wdata}, exp_wr.pop_front());
    end
    if (rdstb) begin
      if (exp_rs.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rdstb_unexpected: got addr=%0h required no rdstb", addr);
      end else chk("rdstb_addr", addr, exp_rs.pop_front());
    end
    if (got_rd.size() > 0) begin
      if (exp_rd.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sdo_unexpected: got %0h required no read word", got_rd.pop_front());
      end else chk("sdo_word", got_rd.pop_front(), exp_rd.pop_front());
    end
  end

  task automatic push_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) txq.push_back(v[i]);
  endtask

  task automatic run_xfer(input logic [1:0] m, input int h, input bit rd, input bit chk_oe,
                          input logic exp_r, input int rst_bit);
    logic [7:0] acc;
    logic so;
    bit oe_on;
    int nb;
    acc = 0; oe_on = chk_oe;
    mode = m; sck = m[1];
    repeat (6) @(posedge clk);
    #3 csb = 1'b0;
    nb = txq.size();
    for (int b = 0; b < nb; b++) begin
      if (b == rst_bit) begin
        #2 rstn = 1'b0;
        #1 chk("rst_mid_outs", {sdo, sdoenb, wrstb, rdstb, busy, pm, pu}, 7'b0100000);
        chk("rst_mid_addr_wdata", {addr, wdata}, 16'h0);
        #7 rstn = 1'b1;
        oe_on = 1'b0; rd = 1'b0;
      end
      if (!m[0]) begin
        sdi = txq[b];
        #(h * 10);
        so = sdo;
        if (b >= 16 && oe_on) chk("sdoenb_data", sdoenb, !exp_r);
        sck = ~sck;
        #(h * 10);
        sck = ~sck;
      end else begin
        #(h * 10);
        sck = ~sck;
        sdi = txq[b];
        #(h * 10);
        so = sdo;
        if (b >= 16 && oe_on) chk("sdoenb_data", sdoenb, !exp_r);
        sck = ~sck;
      end
      if (b >= 16 && rd) begin
        acc = {acc[6:0], so};
        if ((b - 16) % 8 == 7) got_rd.push_back(acc);
      end
    end
    txq.delete();
    #(h * 10);
  endtask

  task automatic txn(input logic [1:0] m, input int h, input logic [7:0] cmd, input logic [7:0] a,
                     input int words, input int extra, input int rst_bit);
    logic w, r, pmx, pux, eoe;
    logic [2:0] n;
    logic [7:0] d;
    bit live;
    w = cmd[7]; r = cmd[6]; n = cmd[5:3];
`ifdef HKSPI_SYNC_PASSTHRU_EN
    pmx = cmd[2]; pux = !cmd[2] && cmd[1];
`else
    pmx = 1'b0; pux = 1'b0;
`endif
    live = !(pmx || pux) && rst_bit < 0;
    push_byte(cmd);
    push_byte(a);
    if (r && live) exp_rs.push_back(a);
    for (int i = 0; i < words; i++) begin
      d = fixd.size() > 0 ? fixd.pop_front() : 8'($urandom);
      push_byte(d);
      if (live) begin
        if (w) exp_wr.push_back({8'(a + i), d});
        if (r) exp_rd.push_back(8'(a + i + 1));
        if (r && i < words - 1) exp_rs.push_back(8'(a + i + 1));
      end
    end
    for (int i = 0; i < extra; i++) txq.push_back(bit'($urandom % 2));
    chk("busy_idle", busy, 0);
    run_xfer(m, h, r && live, !(pmx || pux), r, rst_bit);
    eoe = (pmx || pux) ? 1'b0 : (rst_bit >= 0 || (n != 0 && words == int'(n))) ? 1'b1 : !r;
    chk("busy_end", busy, rst_bit < 0);
    chk("sdoenb_end", sdoenb, eoe);
    chk("pass_mgmt_end", pm, pmx);
    chk("pass_user_end", pu, pux);
    csb = 1'b1;
    repeat (S + 1) @(posedge clk);
    #1 chk("busy_drop", busy, 0);
    chk("pass_drop", {pm, pu}, 0);
    repeat (8) @(posedge clk);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic w, r;
    logic [2:0] n;
    int words, extra;
    rstn = 1'b0; csb = 1'b1; sck = 1'b0; sdi = 1'b0; mode = 2'd0;
    #23 chk("rst_outs", {sdo, sdoenb, wrstb, rdstb, busy, pm, pu}, 7'b0100000);
    chk("rst_addr_wdata", {addr, wdata}, 16'h0);
    rstn = 1'b1;
    repeat (10) @(posedge clk);
    fixd.push_back(8'hA5);
    txn(2'd0, 5, 8'h80, 8'h12, 1, 0, -1);
    txn(2'd3, 5, 8'h58, 8'h20, 3, 0, -1);
    fixd.push_back(8'h12); fixd.push_back(8'h34);
    txn(2'd0, 4, 8'h80, 8'hFF, 2, 0, -1);
    txn(2'd1, 5, 8'hC0, 8'h05, 0, 5, -1);
    txn(2'd0, 5, 8'hC4, 8'h33, 0, 0, -1);
    txn(2'd2, 5, 8'h80, 8'h44, 2, 0, 20);
    txn(2'd2, 5, 8'h80, 8'h45, 1, 0, -1);
    for (int t = 0; t < 30; t++) begin
      r = 1'($urandom % 2);
      w = 1'($urandom % 2);
      if (!r && !w) w = 1'b1;
      if (r) begin
        n = 3'($urandom_range(1, 4)); words = n; extra = 0;
      end else begin
        n = 3'($urandom % 5);
        words = n != 0 ? int'(n) : $urandom_range(1, 3);
        extra = n != 0 ? 0 : $urandom % 8;
      end
      txn(2'($urandom % 4), $urandom_range(4, 6), {w, r, n, 2'b00, 1'($urandom % 2)},
          8'($urandom), words, extra, -1);
    end
    repeat (20) @(posedge clk);
    chk("left_wr", exp_wr.size(), 0);
    chk("left_rdstb", exp_rs.size(), 0);
    chk("left_rd", exp_rd.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
